// File: rtl/status_branch_unit_pkg.sv
// Shared definitions for the status/branch unit: condition codes,
// ALU status bit positions and the redirect FSM encoding.
package status_branch_unit_pkg;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_ALWAYS = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_NZ     = 3'b011;
  localparam logic [2:0] COND_N      = 3'b100;
  localparam logic [2:0] COND_NN     = 3'b101;
  localparam logic [2:0] COND_V      = 3'b110;
  localparam logic [2:0] COND_LT     = 3'b111;

  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_V = 0;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/status_branch_unit_branch_cond_eval.sv
// Combinational branch condition evaluator: maps {Z,N,V} and a 3-bit
// condition code to a taken decision.
module branch_cond_eval
  import status_branch_unit_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  // Decode the condition against the selected flag set.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NEVER:  taken = 1'b0;
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flags[ST_Z];
      COND_NZ:     taken = ~flags[ST_Z];
      COND_N:      taken = flags[ST_N];
      COND_NN:     taken = ~flags[ST_N];
      COND_V:      taken = flags[ST_V];
      COND_LT:     taken = flags[ST_N] ^ flags[ST_V];
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_branch_unit.sv
// Holds the architectural {Z,N,V} flags and resolves flag-conditioned
// branches into a registered, valid/ack-handshaked PC redirect.
module status_branch_unit
  import status_branch_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       alu_status,
  input  logic             stswrite,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic             br_link,
  input  logic [XLEN-1:0]  br_target,
  input  logic [XLEN-1:0]  pc_plus4,
  output logic             redirect_valid,
  input  logic             redirect_ack,
  output logic             redirect_taken,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             link_we,
  output logic [XLEN-1:0]  link_data,
  output logic [2:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rd_state_t        state_q, state_d;
  logic [2:0]       flags_d;
  logic [2:0]       eff_flags_s;
  logic             cond_taken_s;
  logic             accept_s;
  logic             redirect_taken_q, redirect_taken_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             link_we_q, link_we_d;
  logic [XLEN-1:0]  link_data_q, link_data_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  assign br_ready = (state_q == S_EMPTY) | redirect_ack;
  assign accept_s = br_valid & br_ready;

  branch_cond_eval u_cond_eval (
    .flags (eff_flags_s),
    .cond  (br_cond),
    .taken (cond_taken_s)
  );

  // Flag register next state and the flag set a branch is judged against.
  always_comb begin
    flags_d     = flags_q;
    eff_flags_s = flags_q;
    if (stswrite) begin
      flags_d = alu_status;
      if (BYPASS == 1) begin
        eff_flags_s = alu_status;
      end else begin
        eff_flags_s = flags_q;
      end
    end else begin
      flags_d     = flags_q;
      eff_flags_s = flags_q;
    end
  end

  // Redirect FSM, link strobe and saturating counter next state.
  always_comb begin
    state_d          = state_q;
    redirect_taken_d = redirect_taken_q;
    redirect_pc_d    = redirect_pc_q;
    link_we_d        = 1'b0;
    link_data_d      = link_data_q;
    taken_cnt_d      = taken_cnt_q;
    if (accept_s) begin
      // Acceptance while FULL+ack reloads in place, so valid never drops.
      state_d          = S_FULL;
      redirect_taken_d = cond_taken_s;
      if (cond_taken_s) begin
        redirect_pc_d = br_target;
        if (br_link) begin
          link_we_d   = 1'b1;
          link_data_d = pc_plus4;
        end else begin
          link_data_d = link_data_q;
        end
        if (taken_cnt_q != CNT_MAX) begin
          taken_cnt_d = taken_cnt_q + CNT_ONE;
        end else begin
          taken_cnt_d = taken_cnt_q;
        end
      end else begin
        redirect_pc_d = pc_plus4;
      end
    end else if (redirect_ack) begin
      state_d = S_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // All architectural state; reset discards any pending redirect at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_EMPTY;
      flags_q          <= 3'b000;
      redirect_taken_q <= 1'b0;
      redirect_pc_q    <= {XLEN{1'b0}};
      link_we_q        <= 1'b0;
      link_data_q      <= {XLEN{1'b0}};
      taken_cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q          <= state_d;
      flags_q          <= flags_d;
      redirect_taken_q <= redirect_taken_d;
      redirect_pc_q    <= redirect_pc_d;
      link_we_q        <= link_we_d;
      link_data_q      <= link_data_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign redirect_valid = (state_q == S_FULL);
  assign redirect_taken = redirect_taken_q;
  assign redirect_pc    = redirect_pc_q;
  assign link_we        = link_we_q;
  assign link_data      = link_data_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed bench: instance A (BYPASS=1, CNT_W=2) and instance B (BYPASS=0,
// CNT_W=16) share stimulus; expectations are hand-computed constants.
module tb_status_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  alu_status;
  logic        stswrite;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic        br_link;
  logic [31:0] br_target;
  logic [31:0] pc_plus4;
  logic        redirect_ack;

  logic        rdy_a, val_a, tkn_a, lwe_a;
  logic [31:0] pc_a, ld_a;
  logic [2:0]  flg_a;
  logic [1:0]  cnt_a;
  logic        rdy_b, val_b, tkn_b, lwe_b;
  logic [31:0] pc_b, ld_b;
  logic [2:0]  flg_b;
  logic [15:0] cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  status_branch_unit #(.XLEN(32), .BYPASS(1), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .alu_status(alu_status), .stswrite(stswrite),
    .br_valid(br_valid), .br_ready(rdy_a), .br_cond(br_cond), .br_link(br_link),
    .br_target(br_target), .pc_plus4(pc_plus4), .redirect_valid(val_a),
    .redirect_ack(redirect_ack), .redirect_taken(tkn_a), .redirect_pc(pc_a),
    .link_we(lwe_a), .link_data(ld_a), .flags_q(flg_a), .taken_cnt(cnt_a)
  );

  status_branch_unit #(.XLEN(32), .BYPASS(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .alu_status(alu_status), .stswrite(stswrite),
    .br_valid(br_valid), .br_ready(rdy_b), .br_cond(br_cond), .br_link(br_link),
    .br_target(br_target), .pc_plus4(pc_plus4), .redirect_valid(val_b),
    .redirect_ack(redirect_ack), .redirect_taken(tkn_b), .redirect_pc(pc_b),
    .link_we(lwe_b), .link_data(ld_b), .flags_q(flg_b), .taken_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [2:0] c, input logic l, input logic [31:0] t, input logic [31:0] p);
    br_valid  = 1'b1;
    br_cond   = c;
    br_link   = l;
    br_target = t;
    pc_plus4  = p;
  endtask

  initial begin
    reset = 1'b1; alu_status = 3'b000; stswrite = 1'b0; br_valid = 1'b0;
    br_cond = 3'b000; br_link = 1'b0; br_target = 32'h0; pc_plus4 = 32'h0;
    redirect_ack = 1'b0;
    step(); step();
    check("rst_valid", 32'(val_a), 32'd0);
    check("rst_taken", 32'(tkn_a), 32'd0);
    check("rst_pc", pc_a, 32'h0);
    check("rst_link_we", 32'(lwe_a), 32'd0);
    check("rst_link_data", ld_a, 32'h0);
    check("rst_flags", 32'(flg_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_ready", 32'(rdy_a), 32'd1);
    reset = 1'b0;
    step();

    // Reset while FULL
    stswrite = 1'b1; alu_status = 3'b001;
    branch(3'b001, 1'b0, 32'h100, 32'h4);
    step();
    br_valid = 1'b0; stswrite = 1'b0;
    check("full_valid", 32'(val_a), 32'd1);
    check("full_pc", pc_a, 32'h100);
    check("full_flags", 32'(flg_a), 32'd1);
    check("full_cnt", 32'(cnt_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 32'(val_a), 32'd0);
    check("midrst_flags", 32'(flg_a), 32'd0);
    check("midrst_cnt", 32'(cnt_a), 32'd0);
    check("midrst_cnt_b", 32'(cnt_b), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Flag hold
    stswrite = 1'b1; alu_status = 3'b100;
    step();
    stswrite = 1'b0; alu_status = 3'b010;
    step();
    check("hold_flags", 32'(flg_a), 32'h4);
    branch(3'b010, 1'b0, 32'h40, 32'h14);
    step();
    br_valid = 1'b0;
    check("hold_taken_a", 32'(tkn_a), 32'd1);
    check("hold_pc_a", pc_a, 32'h40);
    check("hold_pc_b", pc_b, 32'h40);
    check("hold_cnt_a", 32'(cnt_a), 32'd1);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    check("ack_empty", 32'(val_a), 32'd0);

    // Bypass
    stswrite = 1'b1; alu_status = 3'b000;
    step();
    alu_status = 3'b010;
    branch(3'b100, 1'b0, 32'h80, 32'h24);
    step();
    br_valid = 1'b0; stswrite = 1'b0;
    check("byp_taken_a", 32'(tkn_a), 32'd1);
    check("byp_pc_a", pc_a, 32'h80);
    check("byp_taken_b", 32'(tkn_b), 32'd0);
    check("byp_pc_b", pc_b, 32'h24);
    check("byp_flags_b", 32'(flg_b), 32'h2);
    check("byp_cnt_a", 32'(cnt_a), 32'd2);
    check("byp_cnt_b", 32'(cnt_b), 32'd1);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;

    // Backpressure then back-to-back reload
    branch(3'b001, 1'b0, 32'h200, 32'h30);
    step();
    br_target = 32'h300; pc_plus4 = 32'h34;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 32'(rdy_a), 32'd0);
      check("bp_valid", 32'(val_a), 32'd1);
      check("bp_pc", pc_a, 32'h200);
      step();
    end
    redirect_ack = 1'b1;
    #1;
    check("b2b_ready", 32'(rdy_a), 32'd1);
    step();
    br_valid = 1'b0; redirect_ack = 1'b0;
    check("b2b_valid", 32'(val_a), 32'd1);
    check("b2b_pc", pc_a, 32'h300);
    check("b2b_cnt_a", 32'(cnt_a), 32'd3);
    check("b2b_cnt_b", 32'(cnt_b), 32'd3);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;

    // Link: flags are N=1,V=0 so LT is taken
    branch(3'b111, 1'b1, 32'h500, 32'h2C);
    step();
    br_valid = 1'b0; br_link = 1'b0;
    check("lnk_we", 32'(lwe_a), 32'd1);
    check("lnk_data", ld_a, 32'h2C);
    check("lnk_pc", pc_a, 32'h500);
    check("lnk_cnt_b", 32'(cnt_b), 32'd4);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    check("lnk_pulse_end", 32'(lwe_a), 32'd0);
    check("lnk_data_held", ld_a, 32'h2C);
    stswrite = 1'b1; alu_status = 3'b011;
    step();
    stswrite = 1'b0;
    branch(3'b111, 1'b1, 32'h600, 32'h2C);
    step();
    br_valid = 1'b0; br_link = 1'b0;
    check("nolnk_we", 32'(lwe_a), 32'd0);
    check("nolnk_taken", 32'(tkn_a), 32'd0);
    check("nolnk_pc", pc_a, 32'h2C);
    check("nolnk_cnt_b", 32'(cnt_b), 32'd4);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    branch(3'b000, 1'b1, 32'h700, 32'h70);
    step();
    br_valid = 1'b0; br_link = 1'b0;
    check("never_we", 32'(lwe_a), 32'd0);
    check("never_pc", pc_a, 32'h70);
    check("never_ld", ld_a, 32'h2C);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;

    // Counter saturation from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    branch(3'b000, 1'b0, 32'h900, 32'h90);
    step();
    check("sat_nt_cnt", 32'(cnt_a), 32'd0);
    redirect_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch(3'b001, 1'b0, 32'h1000 + 32'(i * 4), 32'h10);
      step();
      check("sat_cnt_a", 32'(cnt_a), (i < 2) ? 32'(i + 1) : 32'd3);
      check("sat_cnt_b", 32'(cnt_b), 32'(i + 1));
      check("sat_pc", pc_a, 32'h1000 + 32'(i * 4));
      check("sat_valid", 32'(val_a), 32'd1);
    end
    branch(3'b000, 1'b0, 32'hA00, 32'hA0);
    step();
    check("sat_nt_a", 32'(cnt_a), 32'd3);
    check("sat_nt_b", 32'(cnt_b), 32'd5);
    br_valid = 1'b0;
    step();
    redirect_ack = 1'b0;
    check("end_valid", 32'(val_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/status_branch_unit.md
Name: status_branch_unit

Overview:
- Sits directly downstream of the 32-bit ALU and consumes its 3-bit status output (zero, negative, overflow) and the stswrite qualifier.
- Holds the architectural status flags and resolves flag-conditioned branches, including the link variants, for the PC-select logic.
- Output is a registered, valid/ack-handshaked redirect, plus a one-cycle link-register write strobe and a saturating taken-branch counter.

Parameters:
- XLEN, 32, width of PC, target and link data.
- BYPASS, 1, when 1 a branch issued in the same cycle as stswrite evaluates against the incoming flags; when 0 it evaluates against the held flags.
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- alu_status, input, 3, from the ALU: [2]=Z, [1]=N, [0]=V.
- stswrite, input, 1, latch alu_status into the flag register this cycle.
- br_valid, input, 1, a branch request is presented.
- br_ready, output, 1, the unit can accept a request this cycle.
- br_cond, input, 3, condition code (see Behaviour).
- br_link, input, 1, on a taken branch, write pc_plus4 to the link register.
- br_target, input, XLEN, taken target address.
- pc_plus4, input, XLEN, fall-through address.
- redirect_valid, output, 1, a resolved branch is pending.
- redirect_ack, input, 1, the PC unit consumes the resolved branch.
- redirect_taken, output, 1, the resolved branch was taken.
- redirect_pc, output, XLEN, br_target if taken, else pc_plus4.
- link_we, output, 1, one-cycle strobe to the register file.
- link_data, output, XLEN, the captured pc_plus4.
- flags_q, output, 3, the held {Z,N,V}.
- taken_cnt, output, CNT_W, saturating count of taken branches.

Behaviour:
- Reset (async, immediate) values: flags_q=0, redirect_valid=0, redirect_taken=0, redirect_pc=0, link_we=0, link_data=0, taken_cnt=0, FSM=EMPTY.
- Flag register:
  - Updates from alu_status on a clk edge with stswrite=1.
  - Otherwise it holds its value.
  - stswrite has no effect on the redirect FSM.
- Effective flags for evaluation:
  - alu_status if BYPASS=1 and stswrite=1 in the accept cycle.
  - flags_q otherwise.
- Condition codes:
  - 000 never.
  - 001 always.
  - 010 Z.
  - 011 !Z.
  - 100 N.
  - 101 !N.
  - 110 V.
  - 111 N^V (signed less-than).
- Accept: a request is accepted on a rising edge when br_valid=1 and br_ready=1.
- br_ready (combinational) = (FSM==EMPTY) | redirect_ack.
  - This gives full throughput: a new branch can load in the same edge that the old one is acked.
- FSM states EMPTY and FULL:
  - EMPTY, accept -> FULL; outputs are loaded.
  - FULL, redirect_ack and no accept -> EMPTY.
  - FULL, redirect_ack and accept -> FULL; outputs are reloaded with the new branch.
  - FULL, no ack -> FULL; all redirect outputs are held stable, and br_ready=0.
- Latency: one cycle from accept to redirect_valid.
  - redirect_valid = (FSM==FULL).
  - redirect_taken and redirect_pc are registered at accept.
- Link write:
  - link_we=1 for exactly the single cycle after an accept whose branch was taken with br_link=1.
  - link_data=pc_plus4 from that accept; it is held until the next link write.
  - A not-taken link branch gives no link_we.
  - Cond 000 with br_link=1 never writes.
- taken_cnt:
  - Increments by 1 on each accept of a taken branch.
  - Saturates at 2^CNT_W-1; it does not wrap.
- Not-taken branches still produce a redirect (redirect_taken=0, redirect_pc=pc_plus4), so the PC unit sees every branch.
- A reset asserted mid-operation discards the pending redirect immediately, with no ack required.
- br_cond, br_link, br_target and pc_plus4 are sampled only at accept; they are don't-care otherwise.

Decomposition:
- Shared package holds:
  - Condition-code localparams: COND_NEVER, COND_ALWAYS, COND_Z, COND_NZ, COND_N, COND_NN, COND_V, COND_LT.
  - Status bit indices: ST_Z=2, ST_N=1, ST_V=0, matching the ALU packing.
  - FSM state encodings.
- One natural sub-module, branch_cond_eval: purely combinational; takes {flags, cond} and returns taken.
- The top-level module holds the flag register, the FSM, the output registers and the counter.

Test Plan:
- Reset mid-FULL:
  - Stimulus: accept cond=001, target=0x100; assert reset before ack.
  - Required: redirect_valid=0 immediately, flags_q=0, taken_cnt=0.
- Flag hold:
  - Stimulus: stswrite=1 with alu_status=100, then stswrite=0 with alu_status=010; then branch cond=010, target=0x40, pc_plus4=0x14.
  - Required: next cycle redirect_taken=1, redirect_pc=0x40.
- Bypass:
  - Stimulus: flags_q=000; in the same cycle stswrite=1, alu_status=010, br_valid with cond=100.
  - Required: taken=1 with BYPASS=1; taken=0 with BYPASS=0.
- Backpressure and back-to-back:
  - Stimulus: hold redirect_ack=0 for 3 cycles with br_valid asserted.
  - Required: br_ready=0 and outputs stable throughout. When ack=1 with a new request, the next cycle shows the new redirect_pc and redirect_valid never drops.
- Link:
  - Stimulus: cond=111 with N=1, V=0, br_link=1, pc_plus4=0x2C.
  - Required: link_we is a single-cycle pulse with link_data=0x2C. Repeating with N=1, V=1 gives no link_we and redirect_pc=0x2C.
- Counter saturation:
  - Stimulus: CNT_W=2; five taken branches.
  - Required: taken_cnt sequence 1,2,3,3,3; not-taken branches do not change the count.
